// File: rtl/onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : onehot_rr_arbiter
// Purpose  : Round-robin arbiter sharing one 1-of-N resource among N
//            requesters. The winner index is decoded to a registered one-hot
//            grant that can drive the shared resource's select lines
//            directly. Priority rotates past each released owner, every
//            grant has an optional hold limit, and there is always one idle
//            turnaround cycle between owners.
//
// Parameters
//   N         number of requesters (2..32)
//   MAX_HOLD  max consecutive grant cycles per owner, 0 = unlimited
//   CNT_W     hold counter width, must be able to hold MAX_HOLD-1
//   IDX_W     derived, $clog2(N)
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   req        in   N      level requests, bit i = requester i
//   done       in   N      release pulses, only the owner's bit is honoured
//   gnt        out  N      registered one-hot grant, zero when idle
//   gnt_idx    out  IDX_W  binary index of the owner (valid with gnt_valid)
//   gnt_valid  out  1      high while any grant is held (|gnt)
//   timeout    out  1      one-cycle pulse after a hold-limit release
//
// Revision : 1.0  initial release
// ============================================================================
module onehot_rr_arbiter #(
  parameter  int N        = 8,
  parameter  int MAX_HOLD = 15,
  parameter  int CNT_W    = 4,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // N and N-1 expressed in the widths they are compared against.
  localparam logic [IDX_W:0]   c_n_ext    = (IDX_W+1)'(N);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N-1);
  localparam logic [N-1:0]     c_one_hot0 = N'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [N-1:0]     r_gnt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic             r_timeout;

  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0] w_hold_nxt;
  logic [N-1:0]     w_gnt_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_timeout_nxt;

  // --------------------------------------------------------------------------
  // Rotating priority scan: first requester at ptr, ptr+1, ... (mod N).
  // The scan position is kept one bit wider so ptr+k can be folded back
  // below N without relying on N being a power of two.
  // --------------------------------------------------------------------------
  logic             w_found;
  logic [IDX_W-1:0] w_winner;
  logic [IDX_W:0]   w_scan;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_scan   = '0;
    for (int k = 0; k < N; k++) begin
      w_scan = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_scan >= c_n_ext) begin
        w_scan = w_scan - c_n_ext;
      end
      if (!w_found && req[w_scan[IDX_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_scan[IDX_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Owner-side release terms
  // --------------------------------------------------------------------------
  logic             w_owner_done;
  logic             w_owner_req;
  logic             w_limit;
  logic             w_release;
  logic [IDX_W-1:0] w_ptr_after_owner;

  assign w_owner_done = done[r_gnt_idx];
  assign w_owner_req  = req[r_gnt_idx];

  // Hold limit hit on the edge that ends the MAX_HOLD-th grant cycle:
  // the counter starts at 0 on the grant edge and steps once per held edge.
  generate
    if (MAX_HOLD == 0) begin : g_limit_off
      assign w_limit = 1'b0;
    end else begin : g_limit_on
      localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);
      assign w_limit = (r_hold_cnt == c_hold_last);
    end
  endgenerate

  assign w_release = w_owner_done || !w_owner_req || w_limit;

  // Priority moves to the requester just after the releasing owner.
  assign w_ptr_after_owner = (r_gnt_idx == c_last_idx) ? '0
                                                        : r_gnt_idx + IDX_W'(1);

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    w_gnt_nxt     = r_gnt;
    w_idx_nxt     = r_gnt_idx;
    w_timeout_nxt = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_gnt_nxt = '0;
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = c_one_hot0 << w_winner;
          w_idx_nxt   = w_winner;
          w_hold_nxt  = '0;
        end
      end

      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt   = ST_IDLE;
          w_gnt_nxt     = '0;
          w_ptr_nxt     = w_ptr_after_owner;
          // Flag only releases forced by the limit; a done or a dropped
          // request on the same edge counts as a normal release.
          w_timeout_nxt = w_limit && !w_owner_done && w_owner_req;
        end else begin
          w_hold_nxt = r_hold_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_gnt_idx  <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_idx  <= w_idx_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = |r_gnt;
  assign timeout   = r_timeout;

endmodule
`default_nettype wire
